// File: rtl/disp_pixbuf_if.sv
// Bus bundle for disp_pixbuf: frame-fetch write side, display timing side, status.
// The master modport belongs to the fetch/timing logic, the slave modport to the buffer.
interface disp_pixbuf_if #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned DEPTH  = 512
);
  logic                     FIFORST;
  logic                     DISPON;
  logic [WORD_W-1:0]        FIFOIN;
  logic                     FIFOWR;
  logic                     BUF_WREADY;
  logic [$clog2(DEPTH):0]   BUF_LEVEL;
  logic                     BUF_OVER;
  logic                     BUF_UNDER;
  logic                     DSP_preDE;
  logic [7:0]               DSP_R;
  logic [7:0]               DSP_G;
  logic [7:0]               DSP_B;
  logic                     DSP_DE;

  modport master (
    output FIFORST, DISPON, FIFOIN, FIFOWR, DSP_preDE,
    input  BUF_WREADY, BUF_LEVEL, BUF_OVER, BUF_UNDER, DSP_R, DSP_G, DSP_B, DSP_DE
  );

  modport slave (
    input  FIFORST, DISPON, FIFOIN, FIFOWR, DSP_preDE,
    output BUF_WREADY, BUF_LEVEL, BUF_OVER, BUF_UNDER, DSP_R, DSP_G, DSP_B, DSP_DE
  );
endinterface

// File: rtl/disp_pixbuf.sv
// Pixel FIFO: stores packed multi-pixel words, unpacks one RGB888 pixel per DSP_preDE.
// Build option DISP_PIXBUF_FILL_EN: underflow cycles output FILL_RGB instead of the last pixel.
module disp_pixbuf #(
  parameter int unsigned WORD_W       = 64,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned WMARK        = 256,
  parameter logic [23:0] FILL_RGB     = 24'h000000
) (
  input logic          ACLK,
  input logic          ARSTN,
  disp_pixbuf_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LANE_W = WORD_W / PIX_PER_WORD;
  localparam int unsigned IW     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [IW-1:0] LastIdx = IW'(PIX_PER_WORD - 1);
  localparam logic [IW-1:0] IdxOne  = IW'(1);
  localparam logic [AW:0]   PtrOne  = (AW + 1)'(1);
  localparam logic [AW:0]   FullXor = {1'b1, {AW{1'b0}}};

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          over_q, over_d, under_q, under_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d;

  logic [AW:0]       level;
  logic              full, empty, wr_en;
  logic [WORD_W-1:0] head_word;
  logic [23:0]       head_pix;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (wr_ptr_q ^ rd_ptr_q) == FullXor;
  assign empty     = wr_ptr_q == rd_ptr_q;
  assign wr_en     = bus.FIFOWR && !full && !bus.FIFORST;
  assign head_word = mem_q[rd_ptr_q[AW-1:0]];
  assign head_pix  = head_word[32'(idx_q) * LANE_W +: 24];

`ifndef DISP_PIXBUF_FILL_EN
  logic [23:0] unused_fill;
  assign unused_fill = FILL_RGB;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    over_d   = over_q;
    under_d  = under_q;
    rgb_d    = rgb_q;
    de_d     = 1'b0;
    if (bus.FIFORST) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      idx_d    = '0;
      over_d   = 1'b0;
      under_d  = 1'b0;
      rgb_d    = '0;
    end else begin
      // Full is judged on the pre-edge pointers, so a same-cycle pop never frees a slot.
      if (bus.FIFOWR) begin
        if (full) over_d = 1'b1;
        else      wr_ptr_d = wr_ptr_q + PtrOne;
      end
      de_d = bus.DSP_preDE;
      if (bus.DSP_preDE) begin
        if (!empty) begin
          rgb_d = head_pix;
          if (idx_q == LastIdx) begin
            idx_d    = '0;
            rd_ptr_d = rd_ptr_q + PtrOne;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end else begin
          under_d = 1'b1;
`ifdef DISP_PIXBUF_FILL_EN
          rgb_d = FILL_RGB;
`endif
        end
      end
      if (!bus.DISPON) rgb_d = '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      over_q   <= over_d;
      under_q  <= under_d;
      rgb_q    <= rgb_d;
      de_q     <= de_d;
    end
  end

  // Storage is not reset; the pointers define which entries are meaningful.
  always_ff @(posedge ACLK) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.FIFOIN;
  end

  assign bus.BUF_LEVEL  = level;
  assign bus.BUF_WREADY = (DEPTH - 32'(level)) >= WMARK;
  assign bus.BUF_OVER   = over_q;
  assign bus.BUF_UNDER  = under_q;
  assign bus.DSP_R      = rgb_q[23:16];
  assign bus.DSP_G      = rgb_q[15:8];
  assign bus.DSP_B      = rgb_q[7:0];
  assign bus.DSP_DE     = de_q;

endmodule

// File: tb/tb_disp_pixbuf.sv
// Scoreboard bench for disp_pixbuf: a pixel-queue reference model feeds expected pixels,
// a negedge monitor compares them whenever DSP_DE is high.
module tb_disp_pixbuf;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned PPW    = 2;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned WMARK  = 4;
  localparam int unsigned LANE_W = WORD_W / PPW;
  localparam logic [23:0] FILL   = 24'h5A6B7C;

  logic ACLK  = 1'b0;
  logic ARSTN = 1'b0;

  disp_pixbuf_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

  disp_pixbuf #(
    .WORD_W      (WORD_W),
    .PIX_PER_WORD(PPW),
    .DEPTH       (DEPTH),
    .WMARK       (WMARK),
    .FILL_RGB    (FILL)
  ) dut (
    .ACLK (ACLK),
    .ARSTN(ARSTN),
    .bus  (bus)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Reference model: every stored pixel in display order, plus the visible output state.
  logic [23:0] pix_q [$];
  logic [23:0] exp_q [$];
  logic        over_m  = 1'b0;
  logic        under_m = 1'b0;
  logic        de_m    = 1'b0;
  logic [23:0] rgb_m   = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int unsigned mlevel();
    return (pix_q.size() + PPW - 1) / PPW;
  endfunction

  function automatic logic [31:0] dut_rgb();
    return {8'h00, bus.DSP_R, bus.DSP_G, bus.DSP_B};
  endfunction

  always @(negedge ACLK) begin
    if (ARSTN && bus.DSP_DE) begin
      if (exp_q.size() == 0) chk("scoreboard_underrun", 32'd1, 32'd0);
      else chk("pixel", dut_rgb(), {8'h00, exp_q.pop_front()});
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_level"}, 32'(bus.BUF_LEVEL), mlevel());
    chk({tag, "_wready"}, 32'(bus.BUF_WREADY), 32'((DEPTH - mlevel()) >= WMARK));
    chk({tag, "_over"}, 32'(bus.BUF_OVER), 32'(over_m));
    chk({tag, "_under"}, 32'(bus.BUF_UNDER), 32'(under_m));
    chk({tag, "_de"}, 32'(bus.DSP_DE), 32'(de_m));
    chk({tag, "_rgb"}, dut_rgb(), {8'h00, rgb_m});
  endtask

  task automatic step(input logic rst, input logic on, input logic wr, input logic [63:0] w,
                      input logic pre, input string tag);
    bit full, empty;
    bus.FIFORST   = rst;
    bus.DISPON    = on;
    bus.FIFOWR    = wr;
    bus.FIFOIN    = w;
    bus.DSP_preDE = pre;
    full  = (mlevel() == DEPTH);
    empty = (pix_q.size() == 0);
    if (rst) begin
      pix_q.delete();
      over_m  = 1'b0;
      under_m = 1'b0;
      rgb_m   = '0;
      de_m    = 1'b0;
    end else begin
      de_m = pre;
      if (pre) begin
        if (!empty) rgb_m = pix_q.pop_front();
        else begin
          under_m = 1'b1;
`ifdef DISP_PIXBUF_FILL_EN
          rgb_m = FILL;
`endif
        end
      end
      if (!on) rgb_m = '0;
      if (pre) exp_q.push_back(rgb_m);
      if (wr) begin
        if (full) over_m = 1'b1;
        else for (int k = 0; k < PPW; k++) pix_q.push_back(w[k*LANE_W +: 24]);
      end
    end
    @(posedge ACLK);
    #1;
    check_state(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, tag);
  endtask

  initial begin
    logic [63:0] w;
    bus.FIFORST   = 1'b0;
    bus.DISPON    = 1'b1;
    bus.FIFOWR    = 1'b0;
    bus.FIFOIN    = '0;
    bus.DSP_preDE = 1'b0;

    #2;
    chk("rst_level", 32'(bus.BUF_LEVEL), 32'd0);
    chk("rst_rgb", dut_rgb(), 32'd0);
    chk("rst_de", 32'(bus.DSP_DE), 32'd0);
    chk("rst_flags", {30'd0, bus.BUF_OVER, bus.BUF_UNDER}, 32'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    #1 ARSTN = 1'b1;
    #1 chk("rst_wready", 32'(bus.BUF_WREADY), 32'd1);

    // Unpack order: lane 0 (low half) first.
    step(1'b0, 1'b1, 1'b1, {32'h00AABBCC, 32'h00112233}, 1'b0, "t1_wr");
    step(1'b0, 1'b1, 1'b1, {32'h00DDEEFF, 32'h00445566}, 1'b0, "t1_wr");
    step(1'b0, 1'b1, 1'b1, {32'h00123456, 32'h00778899}, 1'b0, "t1_wr");
    chk("t1_level3", 32'(bus.BUF_LEVEL), 32'd3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, "t1_rd");
    chk("t1_last_pix", dut_rgb(), 32'h00AABBCC - 32'h00AABBCC + 32'h00123456);
    idle(1, "t1_idle");

    // Fill to full and overflow.
    for (int i = 0; i < 9; i++) begin
      w = {$urandom(), $urandom()};
      step(1'b0, 1'b1, 1'b1, w, 1'b0, "t2_wr");
    end
    chk("t2_full_level", 32'(bus.BUF_LEVEL), 32'd8);
    chk("t2_over", 32'(bus.BUF_OVER), 32'd1);
    chk("t2_wready_full", 32'(bus.BUF_WREADY), 32'd0);
    // Write while full with a simultaneous pop is still rejected.
    step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "t2_wr_pop");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, "t2_rd");
    chk("t6_level5", 32'(bus.BUF_LEVEL), 32'd5);
    step(1'b1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, "t6_flush");
    chk("t6_flush_level", 32'(bus.BUF_LEVEL), 32'd0);
    chk("t6_flush_wready", 32'(bus.BUF_WREADY), 32'd1);

    // Underflow.
    step(1'b0, 1'b1, 1'b1, {32'h00C0FFEE, 32'h00BEEF01}, 1'b1, "t3_pre");
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, "t3_pre");
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, "t3_pre");
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, "t3_under");
    chk("t3_under_flag", 32'(bus.BUF_UNDER), 32'd1);

    // Partial word stays at head across a DE gap.
    step(1'b0, 1'b1, 1'b1, {32'h00654321, 32'h00ABCDEF}, 1'b0, "t4_wr");
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, "t4_lane0");
    idle(5, "t4_gap");
    chk("t4_gap_level", 32'(bus.BUF_LEVEL), 32'd1);
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, "t4_lane1");
    chk("t4_lane1_pix", dut_rgb(), 32'h00654321);

    // DISPON=0 still consumes pixels.
    step(1'b0, 1'b1, 1'b1, {$urandom(), $urandom()}, 1'b0, "t5_wr");
    step(1'b0, 1'b1, 1'b1, {$urandom(), $urandom()}, 1'b0, "t5_wr");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, "t5_off");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
           "rnd");
    end

    // Asynchronous reset in the middle of reading.
    step(1'b0, 1'b1, 1'b1, {$urandom(), $urandom()}, 1'b1, "t6_pre");
    step(1'b0, 1'b1, 1'b1, {$urandom(), $urandom()}, 1'b1, "t6_pre");
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, "t6_pre");
    @(negedge ACLK);
    #1 ARSTN = 1'b0;
    #1;
    chk("arst_level", 32'(bus.BUF_LEVEL), 32'd0);
    chk("arst_rgb", dut_rgb(), 32'd0);
    chk("arst_de", 32'(bus.DSP_DE), 32'd0);
    chk("arst_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    pix_q.delete();
    over_m  = 1'b0;
    under_m = 1'b0;
    rgb_m   = '0;
    de_m    = 1'b0;
    #1 ARSTN = 1'b1;
    idle(2, "post_arst");

    @(negedge ACLK);
    #1 chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
